blastn_ungapped_extend: RTL

Ungapped-extension engine for the BLASTN accelerator. It sits directly downstream of the control unit. It accepts one 128-bit seed-hit message {db_pos, q_pos, db_seq, query_seq} carrying two 16-base, 2-bit-packed sequences. It extends the seed right, then left, one base per cycle with X-drop termination, and returns a 32-bit result word that the control unit exposes as four byte-wide read registers.

---
 rtl/blastn_ungapped_extend_if.sv | 28 ++
 rtl/blastn_ungapped_extend.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/blastn_ungapped_extend_if.sv
// Seed-in / result-out handshake bundle for the BLASTN ungapped-extension engine.
// The engine is the slave: it receives seeds and produces results.
interface blastn_ungapped_extend_if;
    logic         istream_val;
    logic         istream_rdy;
    logic [127:0] istream_msg;
    logic         ostream_val;
    logic         ostream_rdy;
    logic [31:0]  ostream_msg;

    modport slave (
        input  istream_val,
        input  istream_msg,
        output istream_rdy,
        output ostream_val,
        output ostream_msg,
        input  ostream_rdy
    );

    modport master (
        output istream_val,
        output istream_msg,
        input  istream_rdy,
        input  ostream_val,
        input  ostream_msg,
        output ostream_rdy
    );
endinterface

// File: rtl/blastn_ungapped_extend.sv
// Ungapped X-drop extension of a 16-base seed hit: first rightward, then leftward,
// one base per cycle, reporting the summed score and the extended query/db span.
module blastn_ungapped_extend #(
    parameter logic signed [7:0] MATCH    = 8'sd1,
    parameter logic signed [7:0] MISMATCH = -8'sd1,
    parameter logic signed [7:0] XDROP    = 8'sd3
) (
    input  logic                     clk,
    input  logic                     reset,
    blastn_ungapped_extend_if.slave  io
);

    typedef enum logic [1:0] {IDLE, RIGHT, LEFT, DONE} state_e;

    state_e            state_q, state_d;
    logic [31:0]       qseq_q, qseq_d;
    logic [31:0]       dseq_q, dseq_d;
    logic [3:0]        qpos_q, qpos_d;
    logic [3:0]        dpos_q, dpos_d;
    logic signed [7:0] seed_q, seed_d;
    logic signed [7:0] run_q, run_d;
    logic signed [7:0] best_r_q, best_r_d;
    logic signed [7:0] best_l_q, best_l_d;
    logic [3:0]        len_r_q, len_r_d;
    logic [3:0]        len_l_q, len_l_d;
    logic [4:0]        k_q, k_d;

    logic [4:0]        qoff, doff;
    logic              range_stop;
    logic              xdrop_stop;
    logic signed [7:0] step;
    logic signed [7:0] run_nx;
    logic signed [7:0] best_cur;
    logic signed [7:0] best_nx;
    logic              unused_pos_bits;

    assign unused_pos_bits = ^{io.istream_msg[127:100], io.istream_msg[95:68]};

    function automatic logic [1:0] base_at(input logic [31:0] seq, input logic [3:0] idx);
        return seq[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic signed [7:0] pair_score(input logic [1:0] a, input logic [1:0] b);
        return (a == b) ? MATCH : MISMATCH;
    endfunction

    // Offsets are 5 bits wide so bit 4 flags both overrun past 15 and underrun below 0.
    always_comb begin
        if (state_q == LEFT) begin
            qoff = {1'b0, qpos_q} - k_q;
            doff = {1'b0, dpos_q} - k_q;
        end else begin
            qoff = {1'b0, qpos_q} + k_q;
            doff = {1'b0, dpos_q} + k_q;
        end
        range_stop = qoff[4] | doff[4];
        step       = pair_score(base_at(qseq_q, qoff[3:0]), base_at(dseq_q, doff[3:0]));
        best_cur   = (state_q == LEFT) ? best_l_q : best_r_q;
        run_nx     = run_q + step;
        best_nx    = (run_nx > best_cur) ? run_nx : best_cur;
        xdrop_stop = (best_nx - run_nx) > XDROP;
    end

    always_comb begin
        state_d          = state_q;
        qseq_d           = qseq_q;
        dseq_d           = dseq_q;
        qpos_d           = qpos_q;
        dpos_d           = dpos_q;
        seed_d           = seed_q;
        run_d            = run_q;
        best_r_d         = best_r_q;
        best_l_d         = best_l_q;
        len_r_d          = len_r_q;
        len_l_d          = len_l_q;
        k_d              = k_q;
        io.istream_rdy   = 1'b0;
        io.ostream_val   = 1'b0;
        io.ostream_msg   = 32'd0;

        case (state_q)
            IDLE: begin
                io.istream_rdy = 1'b1;
                if (io.istream_val) begin
                    qseq_d   = io.istream_msg[31:0];
                    dseq_d   = io.istream_msg[63:32];
                    qpos_d   = io.istream_msg[67:64];
                    dpos_d   = io.istream_msg[99:96];
                    seed_d   = pair_score(base_at(io.istream_msg[31:0], io.istream_msg[67:64]),
                                          base_at(io.istream_msg[63:32], io.istream_msg[99:96]));
                    run_d    = 8'sd0;
                    best_r_d = 8'sd0;
                    best_l_d = 8'sd0;
                    len_r_d  = 4'd0;
                    len_l_d  = 4'd0;
                    k_d      = 5'd1;
                    state_d  = RIGHT;
                end
            end
            RIGHT, LEFT: begin
                if (range_stop) begin
                    state_d = (state_q == RIGHT) ? LEFT : DONE;
                    run_d   = 8'sd0;
                    k_d     = 5'd1;
                end else begin
                    run_d = run_nx;
                    if (run_nx > best_cur) begin
                        if (state_q == RIGHT) begin
                            best_r_d = run_nx;
                            len_r_d  = k_q[3:0];
                        end else begin
                            best_l_d = run_nx;
                            len_l_d  = k_q[3:0];
                        end
                    end
                    if (xdrop_stop) begin
                        state_d = (state_q == RIGHT) ? LEFT : DONE;
                        run_d   = 8'sd0;
                        k_d     = 5'd1;
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end
            end
            DONE: begin
                io.ostream_val = 1'b1;
                io.ostream_msg = {4'd0, dpos_q - len_l_q,
                                  4'd0, qpos_q + len_r_q,
                                  4'd0, qpos_q - len_l_q,
                                  seed_q + best_r_q + best_l_q};
                if (io.ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            qseq_q   <= 32'd0;
            dseq_q   <= 32'd0;
            qpos_q   <= 4'd0;
            dpos_q   <= 4'd0;
            seed_q   <= 8'sd0;
            run_q    <= 8'sd0;
            best_r_q <= 8'sd0;
            best_l_q <= 8'sd0;
            len_r_q  <= 4'd0;
            len_l_q  <= 4'd0;
            k_q      <= 5'd0;
        end else begin
            state_q  <= state_d;
            qseq_q   <= qseq_d;
            dseq_q   <= dseq_d;
            qpos_q   <= qpos_d;
            dpos_q   <= dpos_d;
            seed_q   <= seed_d;
            run_q    <= run_d;
            best_r_q <= best_r_d;
            best_l_q <= best_l_d;
            len_r_q  <= len_r_d;
            len_l_q  <= len_l_d;
            k_q      <= k_d;
        end
    end

endmodule
